regfile_wb_arbiter: RTL and testbench

Write-back controller for the 64-bit, 32-entry register file. It shares the file's single write port (RdReg3/DataWr/RFWr) between two requesters, A (ALU result) and B (load/memory result), using a valid/ready handshake and round-robin arbitration. It registers the granted write for one cycle and forwards that in-flight value to the two read ports (Rn/Rm) so readers never see stale data. It sits between the execute/memory stages and the register file.

---
 rtl/regfile_wb_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file write port: round-robin
// grant between ALU (A) and load (B), one-cycle write stage with read forwarding.
module regfile_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              rf_wr,
  input  logic [ADDR_W-1:0] rd1_addr,
  input  logic [ADDR_W-1:0] rd2_addr,
  input  logic [DATA_W-1:0] rf_rd1_data,
  input  logic [DATA_W-1:0] rf_rd2_data,
  output logic [DATA_W-1:0] rd1_data,
  output logic [DATA_W-1:0] rd2_data
);

  typedef enum logic {
    PREF_A = 1'b0,
    PREF_B = 1'b1
  } ptr_e;

  localparam logic [ADDR_W-1:0] ZERO_REG = '1;

  ptr_e              ptr_q, ptr_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= PREF_A;
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      wr_q   <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  // Grant (output logic of the pointer FSM)
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!rst) begin
      unique case ({a_valid, b_valid})
        2'b10: a_ready = 1'b1;
        2'b01: b_ready = 1'b1;
        2'b11: begin
          a_ready = (ptr_q == PREF_A);
          b_ready = (ptr_q == PREF_B);
        end
        default: ;
      endcase
    end
  end

  // Pointer next state
  always_comb begin
    ptr_d = ptr_q;
    if (a_ready)
      ptr_d = PREF_B;
    else if (b_ready)
      ptr_d = PREF_A;
  end

  // Write stage capture
  always_comb begin
    grant    = a_ready | b_ready;
    sel_addr = a_ready ? a_addr : b_addr;
    sel_data = a_ready ? a_data : b_data;
    wr_d     = grant && (sel_addr != ZERO_REG);
    addr_d   = grant ? sel_addr : addr_q;
    data_d   = grant ? sel_data : data_q;
  end

  // Reset gates the in-flight write so the file never commits it
  always_comb begin
    rf_wr   = wr_q & ~rst;
    rf_addr = addr_q;
    rf_data = data_q;
  end

  always_comb begin
    rd1_data = rf_rd1_data;
    rd2_data = rf_rd2_data;
    if (rf_wr && (rf_addr == rd1_addr))
      rd1_data = rf_data;
    if (rf_wr && (rf_addr == rd2_addr))
      rd2_data = rf_data;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed steps then random traffic,
// all checked against a transaction-level model.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr;
  logic [63:0] a_data, b_data;
  logic [4:0]  rf_addr;
  logic [63:0] rf_data;
  logic        rf_wr;
  logic [4:0]  rd1_addr, rd2_addr;
  logic [63:0] rf_rd1_data, rf_rd2_data;
  logic [63:0] rd1_data, rd2_data;

  int n_chk  = 0;
  int n_fail = 0;

  // model state: last accepted transaction and arbitration preference
  bit          m_pref_a;
  bit          m_wr;
  logic [4:0]  m_addr;
  logic [63:0] m_data;
  bit          e_ga, e_gb;

  // stand-in register file fed from the DUT write port
  logic [63:0] file [32];

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready),
    .b_addr(b_addr), .b_data(b_data),
    .rf_addr(rf_addr), .rf_data(rf_data), .rf_wr(rf_wr),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rf_rd1_data(rf_rd1_data), .rf_rd2_data(rf_rd2_data),
    .rd1_data(rd1_data), .rd2_data(rd2_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rf_wr) file[rf_addr] <= rf_data;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fwd(logic [4:0] ra, logic [63:0] raw);
    if (!rst && m_wr && m_addr == ra) return m_data;
    return raw;
  endfunction

  // Sample at the falling edge and compare everything with the model
  task automatic observe();
    @(negedge clk);
    e_ga = 0;
    e_gb = 0;
    if (!rst) begin
      if (a_valid && b_valid) begin
        e_ga = m_pref_a;
        e_gb = !m_pref_a;
      end else begin
        e_ga = a_valid;
        e_gb = b_valid;
      end
    end
    check("a_ready", 64'(a_ready), 64'(e_ga));
    check("b_ready", 64'(b_ready), 64'(e_gb));
    check("rf_wr", 64'(rf_wr), 64'(m_wr && !rst));
    if (m_wr && !rst) begin
      check("rf_addr", 64'(rf_addr), 64'(m_addr));
      check("rf_data", rf_data, m_data);
    end
    check("rd1_data", rd1_data, fwd(rd1_addr, rf_rd1_data));
    check("rd2_data", rd2_data, fwd(rd2_addr, rf_rd2_data));
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_pref_a = 1;
      m_wr     = 0;
      m_addr   = '0;
      m_data   = '0;
    end else if (e_ga || e_gb) begin
      m_addr   = e_ga ? a_addr : b_addr;
      m_data   = e_ga ? a_data : b_data;
      m_wr     = (m_addr != 5'd31);
      m_pref_a = e_gb;
    end else begin
      m_wr = 0;
    end
    #1;
  endtask

  task automatic step();
    observe();
    advance();
  endtask

  bit a_hold, b_hold;

  initial begin
    foreach (file[i]) file[i] = '0;
    m_pref_a = 1; m_wr = 0; m_addr = '0; m_data = '0;
    rd1_addr = 0; rd2_addr = 0;
    rf_rd1_data = 0; rf_rd2_data = 0;

    // reset with both requesting
    rst = 1;
    a_valid = 1; a_addr = 10; a_data = 64'h10;
    b_valid = 1; b_addr = 11; b_data = 64'h11;
    observe();
    check("rst_rf_addr", 64'(rf_addr), 64'd0);
    check("rst_rf_data", rf_data, 64'd0);
    advance();
    observe();
    check("rst_a_ready", 64'(a_ready), 64'd0);
    advance();
    rst = 0;
    observe();
    check("first_grant_a", 64'(a_ready), 64'd1);
    advance();
    a_valid = 0;
    step();
    b_valid = 0;

    // single write and forwarding
    a_valid = 1; a_addr = 3; a_data = 64'd1;
    observe();
    check("single_a_ready", 64'(a_ready), 64'd1);
    advance();
    a_valid = 0; rd1_addr = 3; rf_rd1_data = 64'd0;
    observe();
    check("single_rf_addr", 64'(rf_addr), 64'd3);
    check("single_fwd", rd1_data, 64'd1);
    advance();

    // B write restores preference for A
    b_valid = 1; b_addr = 4; b_data = 64'h44;
    step();
    b_valid = 0;

    // round robin
    a_valid = 1; a_addr = 1; a_data = 64'hA;
    b_valid = 1; b_addr = 2; b_data = 64'hB;
    for (int i = 0; i < 4; i++) begin
      observe();
      check("rr_a_ready", 64'(a_ready), 64'(i % 2 == 0));
      if (i > 0) check("rr_rf_addr", 64'(rf_addr), 64'(i % 2 == 1 ? 1 : 2));
      advance();
    end
    a_valid = 0; b_valid = 0;
    observe();
    check("rr_last_addr", 64'(rf_addr), 64'd2);
    advance();

    // zero register
    b_valid = 1; b_addr = 31; b_data = 64'hFFFF;
    observe();
    check("zero_b_ready", 64'(b_ready), 64'd1);
    advance();
    b_valid = 0; rd2_addr = 31; rf_rd2_data = 64'h1234;
    observe();
    check("zero_no_wr", 64'(rf_wr), 64'd0);
    check("zero_rd2", rd2_data, 64'h1234);
    advance();

    // same-address conflict: A first (pointer back at A), B wins
    a_valid = 1; a_addr = 5; a_data = 64'd7;
    b_valid = 1; b_addr = 5; b_data = 64'd9;
    observe();
    check("conf_a_first", 64'(a_ready), 64'd1);
    advance();
    a_valid = 0;
    step();
    b_valid = 0;
    check("conf_file_7", file[5], 64'd7);
    step();
    check("conf_file_9", file[5], 64'd9);

    // reset drops an in-flight write
    a_valid = 1; a_addr = 6; a_data = 64'h55;
    step();
    a_valid = 0; rst = 1;
    observe();
    check("drop_rf_wr", 64'(rf_wr), 64'd0);
    advance();
    rst = 0;
    step();
    check("drop_file", file[6], 64'd0);

    // random traffic honouring the hold-while-not-ready rule
    a_hold = 0; b_hold = 0;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      if (!a_hold) begin
        a_valid = $urandom_range(0, 2) != 0;
        a_addr  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
        a_data  = {$urandom, $urandom};
      end
      if (!b_hold) begin
        b_valid = $urandom_range(0, 2) != 0;
        b_addr  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
        b_data  = {$urandom, $urandom};
      end
      rd1_addr = ($urandom_range(0, 1) == 0) ? m_addr : 5'($urandom_range(0, 31));
      rd2_addr = ($urandom_range(0, 1) == 0) ? m_addr : 5'($urandom_range(0, 31));
      rf_rd1_data = {$urandom, $urandom};
      rf_rd2_data = {$urandom, $urandom};
      observe();
      a_hold = a_valid && !e_ga;
      b_hold = b_valid && !e_gb;
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
